// File: rtl/mem_test_master_if.sv
// Request/response bus between the memory test master and a memory controller.
// The controller answers each request with a single-cycle i_ready pulse.
interface mem_test_master_if;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic [31:0] i_rdata;

  modport master (output o_valid, o_addr, o_wdata, o_wstrb, input i_ready, i_rdata);
  modport slave  (input o_valid, o_addr, o_wdata, o_wstrb, output i_ready, i_rdata);
endinterface

// File: rtl/mem_test_master.sv
// Memory self-test master: writes an LFSR pattern over NUM_WORDS words, then
// reads the words back and compares them, reporting errors and ready timeouts.
module mem_test_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          NUM_WORDS      = 1024,
  parameter logic [31:0] SEED           = 32'hACE1_2345,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  mem_test_master_if.master  bus,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [15:0]        o_err_count,
  output logic [31:0]        o_first_err_addr,
  output logic               o_timeout
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_e;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [16:0] LAST_IDX = 17'(NUM_WORDS);
  localparam logic [31:0] TMO      = 32'(TIMEOUT_CYCLES);

  state_e      state_q;
  logic [16:0] idx_q, idx_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] wait_q, wait_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        valid_q, busy_q, done_q, pass_q, timeout_q;
  logic [15:0] err_q;
  logic [31:0] first_q;
  logic        in_req, tmo_hit;

  always_comb begin
    lfsr_d  = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    idx_d   = idx_q + 17'd1;
    wait_d  = wait_q + 32'd1;
    addr_d  = BASE_ADDR + {13'd0, idx_q, 2'b00};
    in_req  = (state_q == WR_REQ) || (state_q == RD_REQ);
    tmo_hit = in_req && valid_q && !bus.i_ready && (wait_d == TMO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      lfsr_q    <= SEED_EFF;
      wait_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
    end else if (tmo_hit) begin
      // Abort: error count and first error address are kept for inspection.
      timeout_q <= 1'b1;
      pass_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b1;
      state_q   <= DONE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (i_start) begin
            idx_q     <= '0;
            err_q     <= '0;
            first_q   <= '0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            lfsr_q    <= SEED_EFF;
            wait_q    <= '0;
            valid_q   <= 1'b1;
            addr_q    <= BASE_ADDR;
            wdata_q   <= SEED_EFF;
            wstrb_q   <= 4'hF;
            state_q   <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            state_q <= WR_GAP;
          end else begin
            wait_q <= wait_d;
          end
        end
        WR_GAP: begin
          wait_q  <= '0;
          valid_q <= 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            lfsr_q  <= SEED_EFF;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            wstrb_q <= 4'h0;
            state_q <= RD_REQ;
          end else begin
            addr_q  <= addr_d;
            wdata_q <= lfsr_q;
            wstrb_q <= 4'hF;
            state_q <= WR_REQ;
          end
        end
        RD_REQ: begin
          if (bus.i_ready) begin
            if (bus.i_rdata != lfsr_q) begin
              if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
              if (err_q == 16'd0)    first_q <= addr_q;
            end
            valid_q <= 1'b0;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            state_q <= RD_GAP;
          end else begin
            wait_q <= wait_d;
          end
        end
        RD_GAP: begin
          if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_q == 16'd0);
            state_q <= DONE;
          end else begin
            wait_q  <= '0;
            valid_q <= 1'b1;
            addr_q  <= addr_d;
            wstrb_q <= 4'h0;
            state_q <= RD_REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_valid       = valid_q;
  assign bus.o_addr        = addr_q;
  assign bus.o_wdata       = wdata_q;
  assign bus.o_wstrb       = wstrb_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_pass            = pass_q;
  assign o_err_count       = err_q;
  assign o_first_err_addr  = first_q;
  assign o_timeout         = timeout_q;
endmodule

// File: tb/tb_mem_test_master.sv
// Directed bench: a bench-side memory model answers requests 3 cycles after
// valid, and a scoreboard queue holds the expected request sequence.
module tb_mem_test_master;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          NW   = 4;
  localparam logic [31:0] SEED = 32'hACE1_2345;
  localparam int          TMO  = 20;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic clk = 1'b0;
  logic rst, i_start;
  logic o_busy, o_done, o_pass, o_timeout;
  logic [15:0] o_err_count;
  logic [31:0] o_first_err_addr;
  mem_test_master_if bus();

  req_t        sb[$];
  logic [31:0] mem [0:15];
  int          checks = 0;
  int          errors = 0;

  mem_test_master #(.BASE_ADDR(BASE), .NUM_WORDS(NW), .SEED(SEED), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .bus(bus),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_err_count(o_err_count),
    .o_first_err_addr(o_first_err_addr), .o_timeout(o_timeout));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic start_test(input bit push);
    logic [31:0] l;
    l = SEED;
    sb.delete();
    if (push) begin
      for (int i = 0; i < NW; i++) begin
        sb.push_back('{addr: BASE + 32'(4 * i), wdata: l, wstrb: 4'hF});
        l = lfsr_step(l);
      end
      for (int i = 0; i < NW; i++)
        sb.push_back('{addr: BASE + 32'(4 * i), wdata: 32'h0, wstrb: 4'h0});
    end
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk1("busy_after_start", o_busy, 1'b1);
  endtask

  // Serve one request: wait for valid, check it against the scoreboard, and
  // answer with a ready pulse sampled on the third edge after valid rose.
  task automatic serve(input logic [31:0] flip_addr, input bit flip_en, input bit pulse_start);
    req_t e;
    int   n;
    int   idx;
    n = 0;
    while (bus.o_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk1("valid_seen", bus.o_valid, 1'b1);
    chk1("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk32("req_addr", bus.o_addr, e.addr);
    chk32("req_wstrb", 32'(bus.o_wstrb), 32'(e.wstrb));
    if (e.wstrb != 4'h0) chk32("req_wdata", bus.o_wdata, e.wdata);
    if (pulse_start) i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    chk1("valid_held", bus.o_valid, 1'b1);
    chk32("addr_held", bus.o_addr, e.addr);
    idx = int'((e.addr - BASE) >> 2) & 15;
    bus.i_ready = 1'b1;
    if (e.wstrb == 4'h0)
      bus.i_rdata = mem[idx] ^ ((flip_en && e.addr == flip_addr) ? 32'h1 : 32'h0);
    else
      mem[idx] = bus.o_wdata;
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.i_rdata = 32'h0;
    chk1("valid_drop", bus.o_valid, 1'b0);
  endtask

  task automatic finish_test(input logic exp_pass, input logic [15:0] exp_err, input logic [31:0] exp_first);
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk1("done", o_done, 1'b1);
    chk1("pass", o_pass, exp_pass);
    chk32("err_count", 32'(o_err_count), 32'(exp_err));
    chk32("first_err_addr", o_first_err_addr, exp_first);
    chk1("busy_at_done", o_busy, 1'b0);
    chk1("valid_at_done", bus.o_valid, 1'b0);
    chk1("timeout_at_done", o_timeout, 1'b0);
    chk32("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_rdata = 32'h0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk1("rst_valid", bus.o_valid, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_done", o_done, 1'b0);
    chk1("rst_pass", o_pass, 1'b0);
    chk1("rst_timeout", o_timeout, 1'b0);
    chk32("rst_addr", bus.o_addr, 32'h0);
    chk32("rst_wdata", bus.o_wdata, 32'h0);
    chk32("rst_wstrb", 32'(bus.o_wstrb), 32'h0);
    chk32("rst_err", 32'(o_err_count), 32'h0);
    chk32("rst_first", o_first_err_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Spurious ready while idle has no effect
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    @(negedge clk);
    chk1("idle_ready_valid", bus.o_valid, 1'b0);
    chk1("idle_ready_busy", o_busy, 1'b0);
    chk1("idle_ready_done", o_done, 1'b0);

    // Clean pass over an ideal memory
    start_test(1'b1);
    for (int i = 0; i < 2 * NW; i++) serve(32'h0, 1'b0, 1'b0);
    finish_test(1'b1, 16'd0, 32'h0);

    // Single-bit read corruption at 0x8
    start_test(1'b1);
    for (int i = 0; i < 2 * NW; i++) serve(BASE + 32'h8, 1'b1, 1'b0);
    finish_test(1'b0, 16'd1, BASE + 32'h8);

    // Start re-pulsed mid-write is ignored
    start_test(1'b1);
    for (int i = 0; i < 2 * NW; i++) serve(32'h0, 1'b0, i == 1);
    finish_test(1'b1, 16'd0, 32'h0);

    // Ready never arrives: timeout exactly TMO cycles after valid rises
    start_test(1'b0);
    chk1("tmo_valid_up", bus.o_valid, 1'b1);
    repeat (TMO - 1) @(negedge clk);
    chk1("tmo_not_yet", o_timeout, 1'b0);
    chk1("tmo_valid_still", bus.o_valid, 1'b1);
    @(negedge clk);
    chk1("tmo_flag", o_timeout, 1'b1);
    chk1("tmo_done", o_done, 1'b1);
    chk1("tmo_valid_low", bus.o_valid, 1'b0);
    chk1("tmo_pass", o_pass, 1'b0);
    chk1("tmo_busy", o_busy, 1'b0);
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    @(negedge clk);
    chk1("tmo_after_valid", bus.o_valid, 1'b0);
    chk1("tmo_sticky", o_timeout, 1'b1);

    // Reset in the middle of the read phase, then a full passing run
    start_test(1'b1);
    for (int i = 0; i < NW + 1; i++) serve(32'h0, 1'b0, 1'b0);
    begin
      int n;
      n = 0;
      while (bus.o_valid !== 1'b1 && n < 64) begin
        @(negedge clk);
        n++;
      end
    end
    chk32("midrd_wstrb", 32'(bus.o_wstrb), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk1("midrd_valid", bus.o_valid, 1'b0);
    chk1("midrd_busy", o_busy, 1'b0);
    chk1("midrd_done", o_done, 1'b0);
    chk32("midrd_addr", bus.o_addr, 32'h0);
    chk32("midrd_err", 32'(o_err_count), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    start_test(1'b1);
    for (int i = 0; i < 2 * NW; i++) serve(32'h0, 1'b0, 1'b0);
    finish_test(1'b1, 16'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_test_master.md
MEM_TEST_MASTER -- requirements
Module: mem_test_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first test word; bits [1:0] are zero.
REQ-002 SHALL have parameter NUM_WORDS, default 1024, number of 32-bit words tested, range 1..65535.
REQ-003 SHALL have parameter SEED, default 32'hACE1_2345, LFSR seed; a value of 0 is replaced by 32'h1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum number of cycles spent waiting for i_ready.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_start, input, 1, one-cycle start pulse.
REQ-008 SHALL have port o_valid, output, 1, bus request.
REQ-009 SHALL have port i_ready, input, 1, one-cycle completion pulse from the memory controller.
REQ-010 SHALL have port o_addr, output, 32, byte address.
REQ-011 SHALL have port o_wdata, output, 32, write data.
REQ-012 SHALL have port o_wstrb, output, 4, byte enables; 0 means read.
REQ-013 SHALL have port i_rdata, input, 32, read data, valid in the cycle i_ready is high.
REQ-014 SHALL have port o_busy, output, 1, test in progress.
REQ-015 SHALL have port o_done, output, 1, test finished (sticky).
REQ-016 SHALL have port o_pass, output, 1, done with no errors and no timeout.
REQ-017 SHALL have port o_err_count, output, 16, number of mismatching words; saturates at 16'hFFFF.
REQ-018 SHALL have port o_first_err_addr, output, 32, address of the first mismatching word.
REQ-019 SHALL have port o_timeout, output, 1, test aborted on a ready timeout.

Function
REQ-020 SHALL implement the states IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
REQ-021 SHALL, in IDLE or DONE, on i_start: clear the index, the error count, first_err_addr, o_timeout and o_pass; load the LFSR with SEED; enter WR_REQ. o_busy=1 from the next cycle.
REQ-022 SHALL ignore i_start while o_busy=1.
REQ-023 SHALL, in WR_REQ, drive o_valid=1, o_addr=BASE_ADDR+4*index, o_wdata=lfsr and o_wstrb=4'hF, all held stable until i_ready is sampled high.
REQ-024 SHALL, on a WR_REQ cycle with i_ready=1, do the following, all registered: o_valid=0; advance the index and the LFSR; enter WR_GAP.
REQ-025 SHALL spend exactly 1 cycle in WR_GAP with o_valid=0, then enter WR_REQ. If the index equals NUM_WORDS, it SHALL instead reload the LFSR with SEED, clear the index and enter RD_REQ.
REQ-026 SHALL, in RD_REQ, drive o_valid=1, o_addr=BASE_ADDR+4*index and o_wstrb=4'h0, with o_wdata don't-care, held stable until i_ready.
REQ-027 SHALL, on an RD_REQ cycle with i_ready=1, compare i_rdata against lfsr in that cycle. On a mismatch it SHALL increment err_count (saturating); if err_count was 0 it SHALL capture o_addr into o_first_err_addr. It SHALL then advance the index and the LFSR and enter RD_GAP.
REQ-028 SHALL handle RD_GAP as WR_GAP does. When the index equals NUM_WORDS it SHALL enter DONE and set o_pass=(err_count==0 after the final compare).
REQ-029 SHALL, in DONE, hold o_done=1, o_busy=0 and o_valid=0, with all results stable until the next i_start.
REQ-030 SHALL define the LFSR step as next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}. It SHALL advance only on an accepted transfer.
REQ-031 SHALL ignore i_ready whenever o_valid=0, in any state, including a spurious controller pulse after its initialisation.
REQ-032 SHALL maintain a wait counter that clears on entry to WR_REQ or RD_REQ and increments every cycle that o_valid=1 and i_ready=0.
REQ-033 SHALL, when the wait counter reaches TIMEOUT_CYCLES: set o_timeout=1, o_pass=0 and o_valid=0, and enter DONE. The error count is preserved.
REQ-034 SHALL compute the address in 32 bits, modulo 2^32.
REQ-035 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-036 SHALL, with rst=1 at a clk edge, set: state IDLE; o_valid, o_busy, o_done, o_pass and o_timeout to 0; o_addr, o_wdata, o_first_err_addr and o_err_count to 0; o_wstrb to 0; lfsr to SEED.
REQ-037 SHALL abort any in-flight transfer on reset: o_valid is 0 the cycle after reset, and no result is retained.

Verification
REQ-038 SHALL cover: NUM_WORDS=4 with an ideal memory model (ready 3 cycles after valid) -> writes to 0x0, 0x4, 0x8, 0xC with successive LFSR values from SEED, then reads of the same addresses -> o_done=1, o_pass=1, o_err_count=0.
REQ-039 SHALL cover: same setup, with the model flipping bit 0 of the read data at 0x8 -> o_err_count=1, o_first_err_addr=0x8, o_pass=0.
REQ-040 SHALL cover: i_ready tied low after start -> o_timeout=1 and o_done=1 exactly TIMEOUT_CYCLES cycles after o_valid rises, with o_valid=0 afterwards.
REQ-041 SHALL cover: an i_ready pulse while idle, then i_start -> no state change from the pulse, and the first write occurs at BASE_ADDR.
REQ-042 SHALL cover: i_start re-pulsed mid-write -> ignored, with the address sequence unchanged.
REQ-043 SHALL cover: rst asserted mid-read -> all outputs 0 the next cycle; a subsequent i_start runs a full test that passes.
